needle_sched: RTL and testbench

NEEDLE_SCHED -- requirements
Module: needle_sched

---
 rtl/scr_pkg.sv | 20 ++
 rtl/rr_arb.sv | 45 ++++
 rtl/needle_sched.sv | 165 ++++++++++++++++
 tb/tb_needle_sched.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/scr_pkg.sv
// Shared definitions for the needle scheduler: parameter defaults, field
// widths and the scheduler FSM state encoding.
package scr_pkg;
    localparam int N_ND_DEF    = 6;    // needle slots
    localparam int N_STRIP_DEF = 4;    // lanes
    localparam int X_SPAWN_DEF = 630;  // x of a freshly spawned needle
    localparam int X_WALL_DEF  = 50;   // at or below this x a needle retires
    localparam int MIN_GAP_DEF = 120;  // same-lane spacing before a respawn

    localparam int XW = 10;            // x coordinate width
    localparam int YW = 2;             // lane index width
    localparam int HW = 10;            // height width

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_MOVE,
        S_ARB
    } state_e;
endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter. Grants the first requester at or after the pointer.
// The pointer moves to granted lane + 1 only when advance_i is set.
// Ports:
//   clk, rst   - clock, synchronous active-high reset (pointer -> 0)
//   req_i      - per-lane requests
//   advance_i  - commit the current grant and move the pointer
//   gnt_o      - one-hot grant (all zero when nothing is requested)
module rr_arb #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_i,
    input  logic         advance_i,
    output logic [N-1:0] gnt_o
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic          found;
    int            idx;

    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            // walk lanes starting at the pointer, wrapping at N
            idx = int'(ptr_q) + i;
            if (idx >= N) idx = idx - N;
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                ptr_d      = (idx == N - 1) ? '0 : PW'(idx + 1);
            end
        end
        if (!advance_i) ptr_d = ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
endmodule

// File: rtl/needle_sched.sv
// Needle scheduler: once per frame moves every active needle toward the wall,
// retires the ones that reach it, then spawns at most one new needle in a
// lane chosen round-robin among eligible requesters.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   i_frame      - one-cycle frame pulse
//   i_run        - game in play; low forces IDLE and clears all slots
//   i_spawn_req  - per-lane spawn request (level, held until acked)
//   i_height     - per-lane height captured at spawn
//   i_speed      - pixels moved per frame
//   o_spawn_ack  - one-cycle per-lane grant, valid in the ARB cycle
//   nd_x/y/height- per-slot registered needle state (x = 0 means empty)
//   o_pass       - pulses in MOVE when any needle retired
//   o_full       - every slot occupied
//   o_overrun    - sticky: a frame pulse arrived outside WAIT
module needle_sched
    import scr_pkg::*;
#(
    parameter int N_ND    = N_ND_DEF,
    parameter int N_STRIP = N_STRIP_DEF,
    parameter int X_SPAWN = X_SPAWN_DEF,
    parameter int X_WALL  = X_WALL_DEF,
    parameter int MIN_GAP = MIN_GAP_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_frame,
    input  logic                         i_run,
    input  logic [N_STRIP-1:0]           i_spawn_req,
    input  logic [N_STRIP-1:0][HW-1:0]   i_height,
    input  logic [2:0]                   i_speed,
    output logic [N_STRIP-1:0]           o_spawn_ack,
    output logic [N_ND-1:0][XW-1:0]      nd_x,
    output logic [N_ND-1:0][YW-1:0]      nd_y,
    output logic [N_ND-1:0][HW-1:0]      nd_height,
    output logic                         o_pass,
    output logic                         o_full,
    output logic                         o_overrun
);
    localparam logic [XW-1:0] SPAWN_X = XW'(X_SPAWN);
    localparam logic [XW-1:0] GAP_X   = XW'(X_SPAWN - MIN_GAP);
    localparam logic [XW-1:0] WALL_X  = XW'(X_WALL);

    state_e                  state_q, state_d;
    logic [N_ND-1:0][XW-1:0] x_q, x_d;
    logic [N_ND-1:0][YW-1:0] y_q, y_d;
    logic [N_ND-1:0][HW-1:0] h_q, h_d;
    logic                    ovr_q, ovr_d;

    logic [N_ND-1:0]         occ, free_oh;
    logic                    free_found;
    logic [N_STRIP-1:0]      elig, gnt;
    logic                    advance, pass;
    logic [XW-1:0]           wall_lim;
    logic [YW-1:0]           spawn_y;
    logic [HW-1:0]           spawn_h;

    // occupancy, lowest empty slot, and per-lane eligibility (gap rule)
    always_comb begin
        occ        = '0;
        free_oh    = '0;
        free_found = 1'b0;
        elig       = i_spawn_req;
        for (int s = 0; s < N_ND; s++) begin
            occ[s] = (x_q[s] != '0);
            if (!occ[s] && !free_found) begin
                free_found = 1'b1;
                free_oh[s] = 1'b1;
            end
        end
        for (int l = 0; l < N_STRIP; l++)
            for (int s = 0; s < N_ND; s++)
                if (occ[s] && y_q[s] == YW'(l) && x_q[s] > GAP_X) elig[l] = 1'b0;
    end

    assign o_full  = &occ;
    assign advance = (state_q == S_ARB) && i_run && !o_full && (|elig);

    rr_arb #(.N(N_STRIP)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (elig),
        .advance_i (advance),
        .gnt_o     (gnt)
    );

    always_comb begin
        spawn_y = '0;
        spawn_h = '0;
        for (int l = 0; l < N_STRIP; l++)
            if (gnt[l]) begin
                spawn_y = YW'(l);
                spawn_h = i_height[l];
            end
    end

    // retire threshold; X_WALL + 7 never overflows 10 bits
    assign wall_lim = WALL_X + XW'(i_speed);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        h_d     = h_q;
        ovr_d   = ovr_q | (i_frame && state_q != S_WAIT);
        pass    = 1'b0;
        case (state_q)
            S_IDLE: if (i_run) state_d = S_WAIT;
            S_WAIT: if (i_frame) state_d = S_MOVE;
            S_MOVE: begin
                state_d = S_ARB;
                for (int s = 0; s < N_ND; s++)
                    if (occ[s]) begin
                        if (x_q[s] <= wall_lim) begin
                            x_d[s] = '0;
                            pass   = 1'b1;
                        end else begin
                            x_d[s] = x_q[s] - XW'(i_speed);
                        end
                    end
            end
            S_ARB: begin
                state_d = S_WAIT;
                if (advance)
                    for (int s = 0; s < N_ND; s++)
                        if (free_oh[s]) begin
                            x_d[s] = SPAWN_X;
                            y_d[s] = spawn_y;
                            h_d[s] = spawn_h;
                        end
            end
            default: state_d = S_IDLE;
        endcase
        if (!i_run) begin
            state_d = S_IDLE;
            x_d     = '0;
            y_d     = '0;
            h_d     = '0;
            pass    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            h_q     <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            h_q     <= h_d;
            ovr_q   <= ovr_d;
        end
    end

    assign nd_x        = x_q;
    assign nd_y        = y_q;
    assign nd_height   = h_q;
    assign o_overrun   = ovr_q;
    assign o_pass      = pass;
    assign o_spawn_ack = advance ? gnt : '0;
endmodule

// File: tb/tb_needle_sched.sv
module tb_needle_sched;
    logic             clk = 1'b0;
    logic             rst;
    logic             i_frame, i_run;
    logic [3:0]       i_spawn_req;
    logic [3:0][9:0]  i_height;
    logic [2:0]       i_speed;
    logic [3:0]       o_spawn_ack;
    logic [5:0][9:0]  nd_x;
    logic [5:0][1:0]  nd_y;
    logic [5:0][9:0]  nd_height;
    logic             o_pass, o_full, o_overrun;

    int n_assert = 0;
    int n_fail   = 0;
    logic clr2 = 1'b0;

    needle_sched dut (
        .clk         (clk),
        .rst         (rst),
        .i_frame     (i_frame),
        .i_run       (i_run),
        .i_spawn_req (i_spawn_req),
        .i_height    (i_height),
        .i_speed     (i_speed),
        .o_spawn_ack (o_spawn_ack),
        .nd_x        (nd_x),
        .nd_y        (nd_y),
        .nd_height   (nd_height),
        .o_pass      (o_pass),
        .o_full      (o_full),
        .o_overrun   (o_overrun)
    );

    always #20 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // one full WAIT->MOVE->ARB->WAIT pass; samples o_pass in MOVE,
    // o_spawn_ack and nd_x[0] in ARB
    task automatic frame(output logic pas, output logic [3:0] ack, output logic [9:0] xa);
        i_frame = 1'b1;
        tick();
        i_frame = 1'b0;
        pas = o_pass;
        tick();
        ack = o_spawn_ack;
        xa  = nd_x[0];
        tick();
        if (clr2 && ack[2]) i_spawn_req[2] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_run = 1'b0;
        i_frame = 1'b0;
        i_spawn_req = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic       p;
        logic [3:0] a;
        logic [9:0] xa;
        int         cnt;
        int         ng;
        int         g[7];
        int         gf[7];
        int         exp_g[7] = '{0, 1, 2, 3, 0, 1, 3};

        i_height = '0;
        i_speed  = '0;
        rst = 1'b1;
        i_run = 1'b1;
        i_frame = 1'b1;
        i_spawn_req = 4'b1111;
        tick();
        tick();
        // reset state (rst overrides run/frame)
        for (int s = 0; s < 6; s++) chk("rst_nd_x", nd_x[s], 0);
        chk("rst_ack", o_spawn_ack, 0);
        chk("rst_pass", o_pass, 0);
        chk("rst_full", o_full, 0);
        chk("rst_overrun", o_overrun, 0);

        // lane-2 spawn
        do_reset();
        i_run = 1'b1;
        i_speed = 3'd4;
        i_height[2] = 10'd30;
        i_spawn_req = 4'b0100;
        tick();                       // -> WAIT
        i_frame = 1'b1;
        tick();                       // -> MOVE
        i_frame = 1'b0;
        chk("spawn_pass", o_pass, 0);
        tick();                       // -> ARB
        chk("spawn_ack", o_spawn_ack, 4'b0100);
        chk("spawn_x_pre", nd_x[0], 0);
        tick();                       // -> WAIT
        i_spawn_req = '0;
        chk("spawn_x", nd_x[0], 630);
        chk("spawn_y", nd_y[0], 2);
        chk("spawn_h", nd_height[0], 30);
        chk("spawn_ack_off", o_spawn_ack, 0);
        chk("spawn_full", o_full, 0);

        // move and retire at speed 4
        cnt = 0;
        for (int k = 1; k <= 145; k++) begin
            frame(p, a, xa);
            if (k == 1) chk("move_latency", xa, 626);
            chk("move_x", nd_x[0], (k == 145) ? 0 : 630 - 4 * k);
            chk("move_pass", p, (k == 145) ? 1 : 0);
            if (p) cnt++;
        end
        chk("pass_count", cnt, 1);
        chk("no_overrun", o_overrun, 0);

        // gap rule: lane 0 at speed 2
        do_reset();
        i_run = 1'b1;
        i_speed = 3'd2;
        i_spawn_req = 4'b0001;
        tick();
        frame(p, a, xa);
        chk("gap_first", a, 4'b0001);
        cnt = 0;
        for (int k = 2; k <= 60; k++) begin
            frame(p, a, xa);
            if (a != 0) cnt++;
        end
        chk("gap_blocked", cnt, 0);
        frame(p, a, xa);
        chk("gap_second", a, 4'b0001);
        chk("gap_x0", nd_x[0], 510);
        chk("gap_x1", nd_x[1], 630);

        // round-robin fairness and full
        do_reset();
        i_run = 1'b1;
        i_speed = 3'd7;
        for (int l = 0; l < 4; l++) i_height[l] = 10'(l * 10 + 5);
        i_spawn_req = 4'b1111;
        clr2 = 1'b1;
        tick();
        ng = 0;
        for (int f = 1; f <= 120 && ng < 7; f++) begin
            frame(p, a, xa);
            chk("rr_onehot", ($countones(a) <= 1) ? 1 : 0, 1);
            for (int l = 0; l < 4; l++)
                if (a[l] && ng < 7) begin
                    g[ng]  = l;
                    gf[ng] = f;
                    ng++;
                end
            if (f == 18) chk("rr_not_full", o_full, 0);
            if (f == 20) chk("rr_full", o_full, 1);
        end
        clr2 = 1'b0;
        chk("rr_ngrant", ng, 7);
        for (int i = 0; i < 7; i++) chk("rr_order", (i < ng) ? g[i] : -1, exp_g[i]);
        chk("rr_frame5", (ng > 4) ? gf[4] : -1, 19);
        chk("rr_frame7", (ng > 6) ? gf[6] : -1, 84);

        // run drop in ARB, overrun from a frame during MOVE
        do_reset();
        i_run = 1'b1;
        i_speed = 3'd1;
        i_spawn_req = 4'b0001;
        tick();
        frame(p, a, xa);
        chk("drop_spawn", nd_x[0], 630);
        i_spawn_req = 4'b0010;
        i_frame = 1'b1;
        tick();                       // -> MOVE, frame still high
        tick();                       // -> ARB
        i_frame = 1'b0;
        chk("drop_overrun", o_overrun, 1);
        chk("drop_ack_live", o_spawn_ack, 4'b0010);
        i_run = 1'b0;
        #1;
        chk("drop_ack_off", o_spawn_ack, 0);
        tick();                       // -> IDLE
        for (int s = 0; s < 6; s++) chk("drop_nd_x", nd_x[s], 0);
        chk("drop_pass", o_pass, 0);
        chk("drop_ack_idle", o_spawn_ack, 0);
        tick();
        chk("drop_x_hold", nd_x[0], 0);
        chk("drop_overrun_sticky", o_overrun, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
